// File: rtl/bit_count_seq.sv
// -----------------------------------------------------------------------------
// bit_count_seq
//
// Multi-cycle bit counter. One DATA_W-bit word is accepted over a valid/ready
// handshake and scanned CHUNK_W bits per clock for exactly N = DATA_W/CHUNK_W
// clocks. The count reported depends on the mode captured with the word:
//   00 : number of zero bits
//   01 : number of one bits
//   10 : leading zeros (counted from the MSB)
//   11 : trailing zeros (counted from the LSB)
// Latency is fixed: out_valid rises N clocks after the accepting edge. The
// result is held until the consumer takes it; only then does the block
// return to IDLE, so throughput is at best one word per N+2 clocks.
//
// Parameters:
//   DATA_W  - input word width (>= 1)
//   CHUNK_W - bits examined per clock; must divide DATA_W
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   in_valid  in   producer offers a word
//   in_ready  out  block can accept (high only in IDLE)
//   in_data   in   DATA_W word to scan
//   in_mode   in   2-bit count selector (see above)
//   out_valid out  result available
//   out_ready in   consumer takes the result
//   out_count out  $clog2(DATA_W+1)-bit result count
//   out_zero  out  captured word was all zeros
// -----------------------------------------------------------------------------
module bit_count_seq #(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [1:0]                    in_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(DATA_W+1)-1:0]   out_count,
    output logic                          out_zero
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int N     = DATA_W / CHUNK_W;
    // A single-chunk configuration still needs a 1-bit index register.
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    localparam logic [1:0] MODE_ZEROS = 2'b00;
    localparam logic [1:0] MODE_ONES  = 2'b01;
    localparam logic [1:0] MODE_LZ    = 2'b10;
    localparam logic [1:0] MODE_TZ    = 2'b11;

    // Reject configurations the chunked scan cannot cover exactly.
    if (DATA_W < 1 || CHUNK_W < 1 || CHUNK_W > DATA_W || (DATA_W % CHUNK_W) != 0) begin : g_bad_param
        $error("bit_count_seq: CHUNK_W must be >= 1 and divide DATA_W (>= 1)");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    // -------------------------------------------------------------------------
    // Per-chunk counting helpers. CHUNK_W <= DATA_W, so every per-chunk count
    // fits in CNT_W bits.
    // -------------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] chunk_ones(input logic [CHUNK_W-1:0] c);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            n = n + CNT_W'(c[i]);
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] chunk_zeros(input logic [CHUNK_W-1:0] c);
        return CNT_W'(CHUNK_W) - chunk_ones(c);
    endfunction

    // Zeros above the highest set bit of the chunk.
    function automatic logic [CNT_W-1:0] chunk_lead_zeros(input logic [CHUNK_W-1:0] c);
        logic [CNT_W-1:0] n;
        logic             hit;
        n   = '0;
        hit = 1'b0;
        for (int i = CHUNK_W - 1; i >= 0; i--) begin
            if (c[i]) begin
                hit = 1'b1;
            end else if (!hit) begin
                n = n + CNT_W'(1);
            end
        end
        return n;
    endfunction

    // Zeros below the lowest set bit of the chunk.
    function automatic logic [CNT_W-1:0] chunk_trail_zeros(input logic [CHUNK_W-1:0] c);
        logic [CNT_W-1:0] n;
        logic             hit;
        n   = '0;
        hit = 1'b0;
        for (int i = 0; i < CHUNK_W; i++) begin
            if (c[i]) begin
                hit = 1'b1;
            end else if (!hit) begin
                n = n + CNT_W'(1);
            end
        end
        return n;
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // Control and result state (asynchronously reset)
    state_t             state_q,     state_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [CNT_W-1:0]   acc_q,       acc_d;
    logic               stop_q,      stop_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_zero_q,  out_zero_d;

    // Captured operand (loaded on accept, no reset needed)
    logic [DATA_W-1:0]  word_q,      word_d;
    logic [1:0]         mode_q,      mode_d;
    logic               zero_q,      zero_d;

    // -------------------------------------------------------------------------
    // Chunk selection. The working copy of the word is shifted one chunk per
    // clock so the chunk under inspection always sits at a fixed position:
    // the top CHUNK_W bits for leading-zero mode, the bottom bits otherwise.
    // -------------------------------------------------------------------------
    logic [CHUNK_W-1:0] chunk;
    logic               chunk_has_one;
    logic [CNT_W-1:0]   chunk_inc;
    logic [DATA_W-1:0]  word_shifted;

    if (N > 1) begin : g_shift
        assign word_shifted = (mode_q == MODE_LZ)
                            ? {word_q[DATA_W-CHUNK_W-1:0], {CHUNK_W{1'b0}}}
                            : {{CHUNK_W{1'b0}}, word_q[DATA_W-1:CHUNK_W]};
    end else begin : g_no_shift
        // The single chunk is the whole word; nothing left to shift in.
        assign word_shifted = word_q;
    end

    always_comb begin
        chunk = (mode_q == MODE_LZ) ? word_q[DATA_W-1 -: CHUNK_W] : word_q[CHUNK_W-1:0];
        chunk_has_one = |chunk;
        chunk_inc = '0;
        case (mode_q)
            MODE_ZEROS: chunk_inc = chunk_zeros(chunk);
            MODE_ONES:  chunk_inc = chunk_ones(chunk);
            // Once a 1 has been seen the leading/trailing run is over, so later
            // chunks contribute nothing.
            MODE_LZ:    chunk_inc = stop_q ? '0 : chunk_lead_zeros(chunk);
            MODE_TZ:    chunk_inc = stop_q ? '0 : chunk_trail_zeros(chunk);
            default:    chunk_inc = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        stop_d      = stop_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        out_zero_d  = out_zero_q;
        word_d      = word_q;
        mode_d      = mode_q;
        zero_d      = zero_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    word_d  = in_data;
                    mode_d  = in_mode;
                    zero_d  = (in_data == '0);
                    acc_d   = '0;
                    stop_d  = 1'b0;
                    idx_d   = '0;
                    state_d = S_BUSY;
                end
            end

            S_BUSY: begin
                // Always run all N chunks so the latency does not depend on data.
                acc_d  = acc_q + chunk_inc;
                word_d = word_shifted;
                if (mode_q == MODE_LZ || mode_q == MODE_TZ) begin
                    stop_d = stop_q | chunk_has_one;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    out_count_d = acc_q + chunk_inc;
                    out_zero_d  = zero_q;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            S_DONE: begin
                // Result is held until taken; a new word is only accepted once
                // back in IDLE, never in the handoff cycle itself.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control / result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            stop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            stop_q      <= stop_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_zero_q  <= out_zero_d;
        end
    end

    // -------------------------------------------------------------------------
    // Operand registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        word_q <= word_d;
        mode_q <= mode_d;
        zero_q <= zero_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_bit_count_seq.sv
// -----------------------------------------------------------------------------
// tb_bit_count_seq
//
// Directed scenarios on a DATA_W=32 / CHUNK_W=8 instance, plus random sweeps on
// CHUNK_W = 1, 4 and 32 instances running alongside. Expected results are
// queued when a word is accepted and compared when out_valid rises.
// -----------------------------------------------------------------------------
module tb_bit_count_seq;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    typedef struct {
        int cnt;
        bit zero;
        int acc;   // cycle stamp of the accepting edge
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Independent reference: whole-word counts, no notion of chunks.
    function automatic int model(input logic [31:0] d, input logic [1:0] m);
        int n;
        n = 0;
        case (m)
            2'b00: for (int i = 0; i < 32; i++) n += (d[i] == 1'b0) ? 1 : 0;
            2'b01: for (int i = 0; i < 32; i++) n += (d[i] == 1'b1) ? 1 : 0;
            2'b10: for (int i = 31; i >= 0; i--) begin
                       if (d[i]) break;
                       n++;
                   end
            default: for (int i = 0; i < 32; i++) begin
                       if (d[i]) break;
                       n++;
                   end
        endcase
        return n;
    endfunction

    // ---------------------------------------------------------------- main DUT
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_zero;

    bit_count_seq #(.DATA_W(DATA_W), .CHUNK_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_zero  (out_zero)
    );

    exp_t main_q[$];
    exp_t main_e;
    bit   main_pv = 1'b0;

    always @(negedge clk) begin
        if (!rst && out_valid && !main_pv) begin
            if (main_q.size() == 0) begin
                check("main_unexpected_valid", out_valid, 0);
            end else begin
                main_e = main_q.pop_front();
                check("main_count", out_count, main_e.cnt);
                check("main_zero", out_zero, main_e.zero);
                check("main_latency", cyc - main_e.acc, 4);
            end
        end
        main_pv = out_valid;
    end

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] d, input logic [1:0] m, input int exp_cnt);
        int   t;
        exp_t e;
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        e.cnt  = exp_cnt;
        e.zero = (d == 32'h0);
        e.acc  = cyc + 1;
        main_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_rise();
        int t;
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) check("valid_timeout", out_valid, 1);
    endtask

    // ------------------------------------------------------- random sweep DUTs
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int CW = (g == 0) ? 1 : (g == 1) ? 4 : 32;
        localparam int NC = DATA_W / CW;

        logic             s_rst;
        logic             s_iv;
        logic             s_ir;
        logic [31:0]      s_d;
        logic [1:0]       s_m;
        logic             s_ov;
        logic             s_or;
        logic [CNT_W-1:0] s_oc;
        logic             s_oz;

        exp_t q[$];
        exp_t se;
        bit   pv   = 1'b0;
        bit   done = 1'b0;

        bit_count_seq #(.DATA_W(DATA_W), .CHUNK_W(CW)) u_sw (
            .clk       (clk),
            .rst       (s_rst),
            .in_valid  (s_iv),
            .in_ready  (s_ir),
            .in_data   (s_d),
            .in_mode   (s_m),
            .out_valid (s_ov),
            .out_ready (s_or),
            .out_count (s_oc),
            .out_zero  (s_oz)
        );

        initial begin
            logic [31:0] d;
            logic [1:0]  m;
            int          t;
            exp_t        e;
            s_rst = 1'b1;
            s_iv  = 1'b0;
            s_d   = '0;
            s_m   = '0;
            repeat (3) @(negedge clk);
            s_rst = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 1000; i++) begin
                case (i % 6)
                    0:       d = 32'h0;
                    1:       d = 32'hFFFF_FFFF;
                    2:       d = 32'h1 << $urandom_range(0, 31);
                    3:       d = $urandom >> $urandom_range(0, 31);
                    4:       d = $urandom << $urandom_range(0, 31);
                    default: d = $urandom;
                endcase
                m    = 2'($urandom_range(0, 3));
                s_d  = d;
                s_m  = m;
                s_iv = 1'b1;
                t = 0;
                while (!s_ir && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                if (!s_ir) begin
                    check("sweep_accept_timeout", s_ir, 1);
                    break;
                end
                e.cnt  = model(d, m);
                e.zero = (d == 32'h0);
                e.acc  = cyc + 1;
                q.push_back(e);
                @(posedge clk);
                @(negedge clk);
                s_iv = 1'b0;
                // Inputs change after acceptance and must be ignored.
                s_d  = $urandom;
                s_m  = 2'($urandom_range(0, 3));
            end
            t = 0;
            while (q.size() != 0 && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (q.size() != 0) check("sweep_drain", q.size(), 0);
            done = 1'b1;
        end

        always @(negedge clk) begin
            if (!s_rst && s_ov && !pv) begin
                if (q.size() == 0) begin
                    check("sweep_unexpected_valid", s_ov, 0);
                end else begin
                    se = q.pop_front();
                    check("sweep_count", s_oc, se.cnt);
                    check("sweep_zero", s_oz, se.zero);
                    check("sweep_latency", cyc - se.acc, NC);
                end
            end
            pv   = s_ov;
            s_or = ($urandom_range(0, 3) != 0);
        end
    end

    // --------------------------------------------------------- directed tests
    typedef struct {
        logic [31:0] d;
        logic [1:0]  m;
        int          cnt;
    } vec_t;

    vec_t vecs[$] = '{
        '{32'h0000_00FF, 2'b00, 24},
        '{32'hF0F0_F0F0, 2'b01, 16},
        '{32'h0001_0000, 2'b10, 15},
        '{32'h0001_0000, 2'b11, 16},
        '{32'h8000_0000, 2'b10, 0},
        '{32'h0000_0000, 2'b00, 32},
        '{32'h0000_0000, 2'b01, 0},
        '{32'h0000_0000, 2'b10, 32},
        '{32'h0000_0000, 2'b11, 32},
        '{32'hFFFF_FFFF, 2'b00, 0},
        '{32'hFFFF_FFFF, 2'b01, 32},
        '{32'hFFFF_FFFF, 2'b10, 0},
        '{32'hFFFF_FFFF, 2'b11, 0}
    };

    initial begin
        logic [CNT_W-1:0] c0;
        int               t;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_count", out_count, 0);
        check("reset_out_zero", out_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic handoff timing on the first vector.
        send(vecs[0].d, vecs[0].m, vecs[0].cnt);
        wait_rise();
        check("t1_in_ready_done", in_ready, 0);
        @(negedge clk);
        check("t1_valid_dropped", out_valid, 0);
        check("t1_in_ready_back", in_ready, 1);

        for (int i = 1; i < vecs.size(); i++) begin
            send(vecs[i].d, vecs[i].m, vecs[i].cnt);
            wait_rise();
            @(negedge clk);
        end

        // Backpressure with a new word pending.
        out_ready = 1'b0;
        send(32'h1234_5678, 2'b01, 13);
        wait_rise();
        c0       = out_count;
        in_valid = 1'b1;
        in_data  = 32'h0000_FFFF;
        in_mode  = 2'b10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid_held", out_valid, 1);
            check("bp_count_held", out_count, c0);
            check("bp_in_ready_low", in_ready, 0);
        end
        out_ready = 1'b1;
        send(32'h0000_FFFF, 2'b10, 16);
        wait_rise();
        @(negedge clk);

        // Asynchronous reset two chunks into a scan.
        send(32'hFFFF_0000, 2'b00, 16);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("areset_out_valid", out_valid, 0);
        check("areset_out_count", out_count, 0);
        check("areset_out_zero", out_zero, 0);
        main_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("areset_in_ready", in_ready, 1);
        send(32'h0F00_0000, 2'b10, 4);
        wait_rise();
        @(negedge clk);
        check("main_queue_empty", main_q.size(), 0);

        t = 0;
        while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && t < 60000) begin
            @(negedge clk);
            t++;
        end
        check("sweep_done", g_sw[0].done & g_sw[1].done & g_sw[2].done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
